// File: rtl/ahb_cfg_seq.sv
// ============================================================================
// Module   : ahb_cfg_seq
// Summary  : AHB-Lite master that runs queued write/read/poll commands
//            against the tdm register port, one single transfer at a time.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ahb_cfg_seq #(
    parameter int FIFO_ADDR = 2,
    parameter int TIMEOUT   = 64,
    parameter int POLL_MAX  = 16
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic [31:0] cmd_mask,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_status,
    output logic        busy,
    output logic        hsel,
    output logic [1:0]  htrans,
    output logic [31:0] haddr,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic        hmastlock,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic [1:0]  hresp
);

    localparam int DEPTH = 1 << FIFO_ADDR;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam int PW    = $clog2(POLL_MAX + 1);
    localparam logic [FIFO_ADDR:0] C_DEPTH = (FIFO_ADDR + 1)'(DEPTH);
    localparam logic [TW-1:0]      C_TLAST = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0]      C_PLAST = PW'(POLL_MAX - 1);
    localparam logic [1:0] C_OP_WR = 2'b00, C_OP_POLL = 2'b10, C_OP_NOP = 2'b11;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADDR = 2'd1, S_DATA = 2'd2, S_RESP = 2'd3} state_t;

    logic [97:0]          r_mem [DEPTH];
    logic [FIFO_ADDR-1:0] r_wptr, r_rptr;
    logic [FIFO_ADDR:0]   r_count;
    state_t               r_state;
    logic [1:0]           r_op;
    logic [31:0]          r_addr, r_data, r_mask, r_rdata_w;
    logic                 r_err;
    logic [TW-1:0]        r_tcnt;
    logic [PW-1:0]        r_att;
    logic                 r_hsel, r_hwrite, r_rsp_valid;
    logic [1:0]           r_htrans, r_rsp_status;
    logic [2:0]           r_hsize;
    logic [31:0]          r_haddr, r_hwdata, r_rsp_rdata;

    logic        w_full, w_empty, w_push, w_pop;
    logic [97:0] w_head;
    logic        w_done, w_retry, w_err_any, w_match;
    logic [1:0]  w_status;
    logic [31:0] w_rdat;

    assign w_full    = (r_count == C_DEPTH);
    assign w_empty   = (r_count == '0);
    assign w_push    = cmd_valid && !w_full;
    assign w_pop     = (r_state == S_IDLE) && !w_empty;
    assign w_head    = r_mem[r_rptr];
    assign w_err_any = r_err || (hresp == 2'b01);
    assign w_match   = ((hrdata & r_mask) == (r_data & r_mask));

    always_ff @(posedge hclk) begin
        if (w_push) r_mem[r_wptr] <= {cmd_op, cmd_addr, cmd_data, cmd_mask};
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Decides whether the current phase ends the command, and with what result.
    always_comb begin
        w_done   = 1'b0;
        w_retry  = 1'b0;
        w_status = 2'b00;
        w_rdat   = r_rdata_w;
        case (r_state)
            S_ADDR: begin
                if (!hready && r_tcnt == C_TLAST) begin
                    w_done   = 1'b1;
                    w_status = 2'b10;
                end
            end
            S_DATA: begin
                if (hready) begin
                    if (r_op != C_OP_WR) w_rdat = hrdata;
                    if (w_err_any) begin
                        w_done   = 1'b1;
                        w_status = 2'b01;
                    end else if (r_op != C_OP_POLL || w_match) begin
                        w_done   = 1'b1;
                    end else if (r_att == C_PLAST) begin
                        w_done   = 1'b1;
                        w_status = 2'b11;
                    end else begin
                        w_retry  = 1'b1;
                    end
                end else if (r_tcnt == C_TLAST) begin
                    w_done   = 1'b1;
                    w_status = 2'b10;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state      <= S_IDLE;
            r_op         <= 2'b00;
            r_addr       <= '0;
            r_data       <= '0;
            r_mask       <= '0;
            r_rdata_w    <= '0;
            r_err        <= 1'b0;
            r_tcnt       <= '0;
            r_att        <= '0;
            r_hsel       <= 1'b0;
            r_htrans     <= 2'b00;
            r_haddr      <= '0;
            r_hwrite     <= 1'b0;
            r_hsize      <= 3'b000;
            r_hwdata     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_status <= 2'b00;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_done) begin
                r_state      <= S_RESP;
                r_rsp_valid  <= 1'b1;
                r_rsp_rdata  <= w_rdat;
                r_rsp_status <= w_status;
                r_hsel       <= 1'b0;
                r_htrans     <= 2'b00;
                r_haddr      <= '0;
                r_hwrite     <= 1'b0;
                r_hsize      <= 3'b000;
                r_hwdata     <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_empty) begin
                            {r_op, r_addr, r_data, r_mask} <= w_head;
                            r_att     <= '0;
                            r_rdata_w <= '0;
                            if (w_head[97:96] == C_OP_NOP) begin
                                r_state      <= S_RESP;
                                r_rsp_valid  <= 1'b1;
                                r_rsp_rdata  <= '0;
                                r_rsp_status <= 2'b00;
                            end else begin
                                r_state  <= S_ADDR;
                                r_tcnt   <= '0;
                                r_hsel   <= 1'b1;
                                r_htrans <= 2'b10;
                                r_haddr  <= w_head[95:64];
                                r_hwrite <= (w_head[97:96] == C_OP_WR);
                                r_hsize  <= 3'b010;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (hready) begin
                            r_state  <= S_DATA;
                            r_tcnt   <= '0;
                            r_err    <= 1'b0;
                            r_hsel   <= 1'b0;
                            r_htrans <= 2'b00;
                            r_hwdata <= r_data;
                        end else begin
                            r_tcnt <= r_tcnt + TW'(1);
                        end
                    end
                    S_DATA: begin
                        if (w_retry) begin
                            // Poll mismatch: re-issue the same read.
                            r_state   <= S_ADDR;
                            r_att     <= r_att + PW'(1);
                            r_rdata_w <= hrdata;
                            r_tcnt    <= '0;
                            r_hsel    <= 1'b1;
                            r_htrans  <= 2'b10;
                        end else if (!hready) begin
                            r_tcnt <= r_tcnt + TW'(1);
                            if (hresp == 2'b01) r_err <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign cmd_ready  = !w_full;
    assign busy       = (r_state != S_IDLE) || !w_empty;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_status = r_rsp_status;
    assign hsel       = r_hsel;
    assign htrans     = r_htrans;
    assign haddr      = r_haddr;
    assign hwrite     = r_hwrite;
    assign hsize      = r_hsize;
    assign hburst     = 3'b000;
    assign hmastlock  = 1'b0;
    assign hwdata     = r_hwdata;

endmodule

`default_nettype wire

// File: tb/tb_ahb_cfg_seq.sv
// ============================================================================
// Module   : tb_ahb_cfg_seq
// Summary  : Directed bench for ahb_cfg_seq with a scripted AHB slave and a
//            response scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ahb_cfg_seq;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_addr, cmd_data, cmd_mask;
    logic        rsp_valid, busy;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;
    logic        hsel, hwrite, hmastlock;
    logic [1:0]  htrans;
    logic [31:0] haddr, hwdata, hrdata;
    logic [2:0]  hsize, hburst;
    logic        hready;
    logic [1:0]  hresp;

    ahb_cfg_seq #(.FIFO_ADDR(2), .TIMEOUT(64), .POLL_MAX(16)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
        .busy(busy), .hsel(hsel), .htrans(htrans), .haddr(haddr),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hmastlock(hmastlock),
        .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    always #5 hclk = ~hclk;

    int cyc = 0;
    always @(posedge hclk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  status;
    } exp_t;
    exp_t q[$];

    int n_chk = 0;
    int n_fail = 0;

    // Slave control (written by the main sequence only)
    bit          s_stall = 1'b0;
    int          s_wait = 0;
    int          s_err_id = -1;
    int          rd_start = 0;
    logic [31:0] rd_seq [8];

    // Slave state (written by the slave process only)
    int          nxfer = 0;
    int          cur = 0, wleft = 0, k = 0;
    bit          in_dp = 1'b0, p_rdy = 1'b0, p_ns = 1'b0, p_wr = 1'b0, cur_err = 1'b0;
    logic [31:0] last_hwdata = '0;
    logic        last_hwrite = 1'b0;

    // Scripted AHB slave; decides hready/hresp/hrdata for the coming edge.
    initial begin
        hready = 1'b1;
        hresp  = 2'b00;
        hrdata = '0;
        forever begin
            @(negedge hclk);
            if (in_dp && p_rdy) begin
                in_dp = 1'b0;
            end else if (!in_dp && p_rdy && p_ns) begin
                in_dp       = 1'b1;
                cur         = nxfer;
                nxfer       = nxfer + 1;
                cur_err     = (cur == s_err_id);
                wleft       = cur_err ? 1 : s_wait;
                last_hwrite = p_wr;
            end
            if (in_dp) begin
                hresp = cur_err ? 2'b01 : 2'b00;
                if (wleft > 0) begin
                    hready = 1'b0;
                    hrdata = '0;
                    wleft  = wleft - 1;
                end else begin
                    hready = 1'b1;
                    k      = cur - rd_start;
                    hrdata = (k >= 0 && k < 8) ? rd_seq[k] : 32'h0;
                    last_hwdata = hwdata;
                end
            end else begin
                hready = !s_stall;
                hresp  = 2'b00;
                hrdata = '0;
            end
            p_rdy = hready;
            p_ns  = (htrans == 2'b10);
            p_wr  = hwrite;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] mask, input bit track, input logic [31:0] e_rd,
                        input logic [1:0] e_st, output int acc);
        exp_t e;
        cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_mask = mask;
        cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) break;
            @(negedge hclk);
        end
        chk("cmd_accept", {31'd0, cmd_ready}, 32'd1);
        acc = cyc + 1;
        e.rdata = e_rd;
        e.status = e_st;
        if (track) q.push_back(e);
        @(negedge hclk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int acc, input int lat);
        bit   got;
        exp_t e;
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge hclk);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_rsp_seen"}, {31'd0, got}, 32'd1);
        if (got) begin
            e = (q.size() > 0) ? q.pop_front() : '0;
            chk({tag, "_rdata"}, rsp_rdata, e.rdata);
            chk({tag, "_status"}, {30'd0, rsp_status}, {30'd0, e.status});
            chk({tag, "_htrans_idle"}, {30'd0, htrans}, 32'd0);
            if (lat >= 0) chk({tag, "_latency"}, cyc - acc, lat);
        end
    endtask

    int  acc0, acc1, x0;
    bit  seen;

    initial begin
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_data = '0; cmd_mask = '0;
        for (int i = 0; i < 8; i++) rd_seq[i] = '0;
        repeat (3) @(negedge hclk);
        hresetn = 1'b1;
        @(negedge hclk);

        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_htrans", {30'd0, htrans}, 32'd0);
        chk("rst_hsel", {31'd0, hsel}, 32'd0);
        chk("rst_haddr", haddr, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp", {rsp_rdata[29:0], rsp_status}, 32'd0);

        // Zero-wait write
        x0 = nxfer;
        send(2'b00, 32'h300, 32'h1, 32'h0, 1'b1, 32'h0, 2'b00, acc0);
        wait_rsp("wr", acc0, 3);
        chk("wr_xfers", nxfer - x0, 32'd1);
        chk("wr_hwdata", last_hwdata, 32'h1);
        chk("wr_hwrite", {31'd0, last_hwrite}, 32'd1);

        // Read with three data-phase wait states
        rd_start = nxfer; rd_seq[0] = 32'h8000_0000; s_wait = 3;
        send(2'b01, 32'h100, 32'h0, 32'h0, 1'b1, 32'h8000_0000, 2'b00, acc0);
        wait_rsp("rd_wait", acc0, 6);
        s_wait = 0;
        repeat (3) @(negedge hclk);
        chk("rd_hold", rsp_rdata, 32'h8000_0000);
        chk("rd_hwrite", {31'd0, last_hwrite}, 32'd0);

        // Error response, then a queued read that still runs
        rd_start = nxfer; s_err_id = nxfer; rd_seq[1] = 32'h0000_1234;
        send(2'b00, 32'h000, 32'h55, 32'h0, 1'b1, 32'h0, 2'b01, acc0);
        send(2'b01, 32'h104, 32'h0, 32'h0, 1'b1, 32'h0000_1234, 2'b00, acc1);
        wait_rsp("err", acc0, 4);
        wait_rsp("after_err", acc1, -1);
        s_err_id = -1;

        // Nop
        send(2'b11, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 2'b00, acc0);
        wait_rsp("nop", acc0, 1);

        // Address-phase timeout, then recovery
        s_stall = 1'b1;
        send(2'b01, 32'h200, 32'h0, 32'h0, 1'b1, 32'h0, 2'b10, acc0);
        wait_rsp("tmo", acc0, 65);
        @(negedge hclk);
        chk("tmo_hsel", {31'd0, hsel}, 32'd0);
        s_stall = 1'b0;
        rd_start = nxfer; rd_seq[0] = 32'hCAFE_0001;
        send(2'b01, 32'h204, 32'h0, 32'h0, 1'b1, 32'hCAFE_0001, 2'b00, acc0);
        wait_rsp("tmo_rec", acc0, 3);

        // Poll matching on third attempt
        rd_start = nxfer; x0 = nxfer;
        rd_seq[0] = 32'h0; rd_seq[1] = 32'h0; rd_seq[2] = 32'h8000_FF3C;
        send(2'b10, 32'h000, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h8000_FF3C, 2'b00, acc0);
        wait_rsp("poll", acc0, 7);
        chk("poll_xfers", nxfer - x0, 32'd3);

        // Poll that never matches
        for (int i = 0; i < 8; i++) rd_seq[i] = '0;
        rd_start = nxfer; x0 = nxfer;
        send(2'b10, 32'h008, 32'h1, 32'hFFFF_FFFF, 1'b1, 32'h0, 2'b11, acc0);
        wait_rsp("poll_exh", acc0, 33);
        chk("poll_exh_xfers", nxfer - x0, 32'd16);

        // Fill the FIFO behind a stalled transfer
        s_stall = 1'b1; rd_start = nxfer;
        rd_seq[1] = 32'h11; rd_seq[2] = 32'h22; rd_seq[3] = 32'h33; rd_seq[4] = 32'h44;
        send(2'b00, 32'h010, 32'hA0, 32'h0, 1'b1, 32'h0, 2'b00, acc0);
        for (int i = 1; i <= 4; i++)
            send(2'b01, 32'h20 + 32'(i), 32'h0, 32'h0, 1'b1, rd_seq[i], 2'b00, acc1);
        chk("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("full_busy", {31'd0, busy}, 32'd1);
        s_stall = 1'b0;
        for (int i = 0; i < 5; i++) wait_rsp("fill", 0, -1);
        @(negedge hclk);
        chk("fill_busy_low", {31'd0, busy}, 32'd0);
        chk("fill_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Reset in the middle of a stalled transfer
        s_stall = 1'b1;
        send(2'b01, 32'h040, 32'h0, 32'h0, 1'b0, 32'h0, 2'b00, acc0);
        repeat (4) @(negedge hclk);
        hresetn = 1'b0;
        @(negedge hclk);
        hresetn = 1'b1;
        s_stall = 1'b0;
        @(negedge hclk);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_htrans", {30'd0, htrans}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge hclk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("mrst_no_rsp", {31'd0, seen}, 32'd0);
        rd_start = nxfer; rd_seq[0] = 32'h0BAD_F00D;
        send(2'b01, 32'h044, 32'h0, 32'h0, 1'b1, 32'h0BAD_F00D, 2'b00, acc0);
        wait_rsp("mrst_rec", acc0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
